// File: rtl/xor_hash_pkg.sv
// rtl/xor_hash_pkg.sv - shared encodings for the XOR-replicated URAM hash table
//   status_t   : response codes returned by the write-side engine
//   OPT_*      : request operation encoding
//   wr_state_t : write-engine FSM states
//   valid_pos  : bit position of the valid flag inside an entry
package xor_hash_pkg;

    typedef enum logic [1:0] {
        ST_INSERT  = 2'b00,
        ST_UPDATE  = 2'b01,
        ST_DELETED = 2'b10,
        ST_FAIL    = 2'b11
    } status_t;

    localparam logic OPT_WRITE = 1'b0;
    localparam logic OPT_DEL   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DECIDE,
        S_WRITE,
        S_RESP
    } wr_state_t;

    function automatic int valid_pos(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/xor_all_URAM.sv
// rtl/xor_all_URAM.sv - per-way XOR of all bank copies
//   din  : way i, bank b at [(i*NUM_WR+b)*DATA_WIDTH +: DATA_WIDTH]
//   dout : way i at [i*DATA_WIDTH +: DATA_WIDTH], XOR of its NUM_WR banks
module xor_all_URAM #(
    parameter int NUM_WR     = 8,
    parameter int NUM_MUL    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0] din,
    output logic [NUM_MUL*DATA_WIDTH-1:0]        dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_MUL; i++) begin
            for (int b = 0; b < NUM_WR; b++) begin
                dout[i*DATA_WIDTH +: DATA_WIDTH] = dout[i*DATA_WIDTH +: DATA_WIDTH]
                    ^ din[(i*NUM_WR+b)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/xor_except_uram.sv
// rtl/xor_except_uram.sv - per-way XOR of all bank copies except bank PORT_ID
//   din  : way i, bank b at [(i*NUM_WR+b)*DATA_WIDTH +: DATA_WIDTH]
//   dout : way i at [i*DATA_WIDTH +: DATA_WIDTH], XOR of every bank but PORT_ID
module xor_except_uram #(
    parameter int NUM_WR     = 8,
    parameter int NUM_MUL    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int PORT_ID    = 0
) (
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0] din,
    output logic [NUM_MUL*DATA_WIDTH-1:0]        dout
);

    // XOR everything, then cancel the own bank by XORing it in a second time.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_MUL; i++) begin
            for (int b = 0; b < NUM_WR; b++) begin
                dout[i*DATA_WIDTH +: DATA_WIDTH] = dout[i*DATA_WIDTH +: DATA_WIDTH]
                    ^ din[(i*NUM_WR+b)*DATA_WIDTH +: DATA_WIDTH];
            end
            dout[i*DATA_WIDTH +: DATA_WIDTH] = dout[i*DATA_WIDTH +: DATA_WIDTH]
                ^ din[(i*NUM_WR+PORT_ID)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/xor_uram_writer.sv
// rtl/xor_uram_writer.sv - write-side engine for one bank copy of the XOR-replicated URAM hash table
//   clk, rst                : clock, synchronous active-high reset
//   req_*                   : insert/update/delete request (valid/ready)
//   rd_en, rd_addr          : read strobe/address to every bank and way
//   rd_bram_out             : all ways x banks, RD_LATENCY cycles after rd_en
//   wr_en, wr_way, wr_addr,
//   wr_data                 : encoded write into this unit's own bank
//   resp_valid, resp_ready,
//   resp_status             : result handshake
module xor_uram_writer
    import xor_hash_pkg::*;
#(
    parameter int NUM_WR     = 8,
    parameter int NUM_MUL    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEY_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int PORT_ID    = 0,
    parameter int RD_LATENCY = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_opt,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    input  logic [KEY_WIDTH-1:0]                  req_key,
    input  logic [DATA_WIDTH-1-KEY_WIDTH-1:0]     req_value,
    output logic                                  rd_en,
    output logic [ADDR_WIDTH-1:0]                 rd_addr,
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  rd_bram_out,
    output logic                                  wr_en,
    output logic [NUM_MUL-1:0]                    wr_way,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [DATA_WIDTH-1:0]                 wr_data,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic [1:0]                            resp_status
);

    localparam int VAL_WIDTH = DATA_WIDTH - 1 - KEY_WIDTH;
    localparam int KV_WIDTH  = KEY_WIDTH + 1;
    localparam int VALID_BIT = valid_pos(DATA_WIDTH);
    localparam int CNT_WIDTH = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int BUF_WIDTH = NUM_MUL * NUM_WR * DATA_WIDTH;

    wr_state_t state, state_next;

    logic                         opt_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [KEY_WIDTH-1:0]         key_q;
    logic [VAL_WIDTH-1:0]         val_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic [BUF_WIDTH-1:0]         buf_q;
    status_t                      status_q;
    logic [NUM_MUL-1:0]           way_q;
    logic [DATA_WIDTH-1:0]        data_q;

    logic [NUM_MUL*NUM_WR*KV_WIDTH-1:0] kv_banks;
    logic [NUM_MUL*KV_WIDTH-1:0]        kv_full;
    logic [NUM_MUL*DATA_WIDTH-1:0]      others;

    logic [NUM_MUL-1:0]    way_valid;
    logic [NUM_MUL-1:0]    way_hit;
    logic [NUM_MUL-1:0]    empty_sel;
    logic [NUM_MUL-1:0]    hit_sel;
    logic [DATA_WIDTH-1:0] new_entry;
    logic [DATA_WIDTH-1:0] sel_others;
    status_t               dec_status;
    logic [NUM_MUL-1:0]    dec_way;
    logic [DATA_WIDTH-1:0] dec_data;

    // Only the valid flag and key steer the decision, so the full reduction
    // is taken over those fields alone.
    always_comb begin
        kv_banks = '0;
        for (int j = 0; j < NUM_MUL*NUM_WR; j++) begin
            kv_banks[j*KV_WIDTH +: KV_WIDTH] = {buf_q[j*DATA_WIDTH + VALID_BIT],
                                                buf_q[j*DATA_WIDTH +: KEY_WIDTH]};
        end
    end

    xor_all_URAM #(
        .NUM_WR     (NUM_WR),
        .NUM_MUL    (NUM_MUL),
        .DATA_WIDTH (KV_WIDTH)
    ) u_full (
        .din  (kv_banks),
        .dout (kv_full)
    );

    xor_except_uram #(
        .NUM_WR     (NUM_WR),
        .NUM_MUL    (NUM_MUL),
        .DATA_WIDTH (DATA_WIDTH),
        .PORT_ID    (PORT_ID)
    ) u_others (
        .din  (buf_q),
        .dout (others)
    );

    // Way selection mirrors the read-side arbiter: lowest hit wins, otherwise
    // the highest-index empty way takes the insert.
    always_comb begin
        way_valid  = '0;
        way_hit    = '0;
        empty_sel  = '0;
        hit_sel    = '0;
        dec_status = ST_FAIL;
        dec_way    = '0;
        sel_others = '0;
        for (int i = 0; i < NUM_MUL; i++) begin
            way_valid[i] = kv_full[i*KV_WIDTH + KEY_WIDTH];
            way_hit[i]   = way_valid[i] && (kv_full[i*KV_WIDTH +: KEY_WIDTH] == key_q);
        end
        for (int i = 0; i < NUM_MUL; i++) begin
            if (!way_valid[i]) begin
                empty_sel    = '0;
                empty_sel[i] = 1'b1;
            end
        end
        for (int i = NUM_MUL - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
        if (opt_q == OPT_DEL) begin
            if (|way_hit) begin
                dec_status = ST_DELETED;
                dec_way    = hit_sel;
            end
        end else if (|way_hit) begin
            dec_status = ST_UPDATE;
            dec_way    = hit_sel;
        end else if (|empty_sel) begin
            dec_status = ST_INSERT;
            dec_way    = empty_sel;
        end
        new_entry = (opt_q == OPT_DEL) ? '0 : {1'b1, val_q, key_q};
        for (int i = 0; i < NUM_MUL; i++) begin
            if (dec_way[i]) begin
                sel_others = sel_others | others[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        dec_data = new_entry ^ sel_others;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (req_valid) state_next = S_READ;
            S_READ:   state_next = S_WAIT;
            S_WAIT:   if (cnt_q == '0) state_next = S_DECIDE;
            S_DECIDE: state_next = S_WRITE;
            S_WRITE:  state_next = S_RESP;
            S_RESP:   if (resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opt_q    <= OPT_WRITE;
            addr_q   <= '0;
            key_q    <= '0;
            val_q    <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            status_q <= ST_INSERT;
            way_q    <= '0;
            data_q   <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                opt_q  <= req_opt;
                addr_q <= req_addr;
                key_q  <= req_key;
                val_q  <= req_value;
            end
            if (state == S_READ) begin
                cnt_q <= CNT_WIDTH'(RD_LATENCY - 1);
            end else if (state == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
            if (state == S_WAIT && cnt_q == '0) begin
                buf_q <= rd_bram_out;
            end
            if (state == S_DECIDE) begin
                status_q <= dec_status;
                way_q    <= dec_way;
                data_q   <= dec_data;
            end
        end
    end

    always_comb begin
        req_ready   = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_way      = '0;
        wr_addr     = '0;
        wr_data     = '0;
        resp_valid  = 1'b0;
        resp_status = '0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_READ: begin
                rd_en   = 1'b1;
                rd_addr = addr_q;
            end
            S_WRITE: begin
                wr_en   = (status_q != ST_FAIL);
                wr_way  = way_q;
                wr_addr = addr_q;
                wr_data = data_q;
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                resp_status = status_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xor_uram_writer.sv
// tb/tb_xor_uram_writer.sv - randomized self-checking bench for xor_uram_writer
module tb_xor_uram_writer;

    localparam int NW  = 8;
    localparam int NM  = 4;
    localparam int DW  = 64;
    localparam int KW  = 32;
    localparam int AW  = 12;
    localparam int PID = 0;
    localparam int RL  = 2;
    localparam int VW  = DW - 1 - KW;

    localparam logic [1:0] E_INS  = 2'b00;
    localparam logic [1:0] E_UPD  = 2'b01;
    localparam logic [1:0] E_DEL  = 2'b10;
    localparam logic [1:0] E_FAIL = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid, req_ready, req_opt;
    logic [AW-1:0]     req_addr;
    logic [KW-1:0]     req_key;
    logic [VW-1:0]     req_value;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [NM*NW*DW-1:0] rd_bram_out;
    logic              wr_en;
    logic [NM-1:0]     wr_way;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              resp_valid, resp_ready;
    logic [1:0]        resp_status;

    always #5 clk = ~clk;

    xor_uram_writer #(
        .NUM_WR (NW), .NUM_MUL (NM), .DATA_WIDTH (DW), .KEY_WIDTH (KW),
        .ADDR_WIDTH (AW), .PORT_ID (PID), .RD_LATENCY (RL)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_opt (req_opt),
        .req_addr (req_addr), .req_key (req_key), .req_value (req_value),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_bram_out (rd_bram_out),
        .wr_en (wr_en), .wr_way (wr_way), .wr_addr (wr_addr), .wr_data (wr_data),
        .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_status (resp_status)
    );

    // Table contents at the address under test: cur[way][bank].
    logic [DW-1:0] cur [NM][NW];
    logic [DW-1:0] ent [NM];
    logic [AW-1:0] cur_addr = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [NM-1:0] cap_way;
    logic [AW-1:0] cap_addr, cap_rd_addr;
    logic [DW-1:0] cap_data;
    logic [1:0]    cap_status;

    function automatic logic [NM*NW*DW-1:0] pack_table();
        logic [NM*NW*DW-1:0] v;
        for (int w = 0; w < NM; w++)
            for (int b = 0; b < NW; b++)
                v[(w*NW+b)*DW +: DW] = cur[w][b];
        return v;
    endfunction

    // Two-stage read pipeline: data appears RL cycles after rd_en, random junk otherwise.
    logic [NM*NW*DW-1:0] junk, p0_d, p1_d;
    logic                p0_v = 1'b0, p1_v = 1'b0;
    always @(posedge clk) begin
        for (int j = 0; j < NM*NW*DW/32; j++) junk[j*32 +: 32] <= $urandom;
        p0_v <= rd_en;
        p0_d <= (rd_en && rd_addr == cur_addr) ? pack_table() : junk;
        p1_v <= p0_v;
        p1_d <= p0_d;
    end
    assign rd_bram_out = p1_v ? p1_d : junk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] way_xor(input int w);
        logic [DW-1:0] f;
        f = '0;
        for (int b = 0; b < NW; b++) f = f ^ cur[w][b];
        return f;
    endfunction

    // Reference decision taken straight from the table semantics.
    function automatic void model(input logic opt, input logic [KW-1:0] key,
                                  output logic [1:0] st, output int way);
        logic [DW-1:0] f;
        int hitw, empw;
        hitw = -1;
        empw = -1;
        for (int w = 0; w < NM; w++) begin
            f = way_xor(w);
            if (hitw < 0 && f[DW-1] && f[KW-1:0] == key) hitw = w;
        end
        for (int w = NM - 1; w >= 0; w--) begin
            f = way_xor(w);
            if (empw < 0 && !f[DW-1]) empw = w;
        end
        way = -1;
        st  = E_FAIL;
        if (opt) begin
            if (hitw >= 0) begin st = E_DEL; way = hitw; end
        end else if (hitw >= 0) begin
            st = E_UPD; way = hitw;
        end else if (empw >= 0) begin
            st = E_INS; way = empw;
        end
    endfunction

    // Spread each intended entry across random banks so their XOR equals it.
    task automatic fill_table();
        logic [DW-1:0] acc;
        for (int w = 0; w < NM; w++) begin
            acc = '0;
            for (int b = 0; b < NW - 1; b++) begin
                cur[w][b] = {$urandom, $urandom};
                acc = acc ^ cur[w][b];
            end
            cur[w][NW-1] = ent[w] ^ acc;
        end
    endtask

    task automatic run_txn(input logic opt, input logic [AW-1:0] addr,
                           input logic [KW-1:0] key, input logic [VW-1:0] val, input int hold);
        logic [1:0]    exp_st;
        int            exp_w;
        logic [NM-1:0] exp_way;
        logic [DW-1:0] new_e;
        int rd_k, wr_k, rsp_k, rd_cnt, wr_cnt;
        model(opt, key, exp_st, exp_w);
        exp_way = '0;
        if (exp_w >= 0) exp_way[exp_w] = 1'b1;
        new_e = opt ? '0 : {1'b1, val, key};
        rd_k = -1; wr_k = -1; rsp_k = -1; rd_cnt = 0; wr_cnt = 0;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        cur_addr  = addr;
        req_valid = 1'b1;
        req_opt   = opt;
        req_addr  = addr;
        req_key   = key;
        req_value = val;
        for (int k = 1; k <= 40 && rsp_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_opt   = 1'($urandom);
                req_addr  = AW'($urandom);
                req_key   = $urandom;
                req_value = VW'($urandom);
                check("req_ready_busy", req_ready, 0);
            end
            if (rd_en) begin
                rd_cnt++;
                if (rd_k < 0) rd_k = k;
                cap_rd_addr = rd_addr;
            end
            if (wr_en) begin
                wr_cnt++;
                wr_k     = k;
                cap_way  = wr_way;
                cap_addr = wr_addr;
                cap_data = wr_data;
            end
            if (resp_valid) begin
                rsp_k      = k;
                cap_status = resp_status;
            end
        end
        if (rsp_k < 0) begin
            check("resp_timeout", 0, 1);
            return;
        end
        check("rd_latency", 64'(rd_k), 1);
        check("rd_count", 64'(rd_cnt), 1);
        check("rd_addr", cap_rd_addr, addr);
        check("resp_latency", 64'(rsp_k), 6);
        check("status", cap_status, exp_st);
        check("wr_count", 64'(wr_cnt), (exp_st == E_FAIL) ? 0 : 1);
        if (exp_st != E_FAIL && wr_cnt > 0) begin
            check("wr_latency", 64'(wr_k), 5);
            check("wr_way", cap_way, exp_way);
            check("wr_addr", cap_addr, addr);
            cur[exp_w][PID] = cap_data;
            check("xor_result", way_xor(exp_w), new_e);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_status", resp_status, exp_st);
            check("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("release_valid", resp_valid, 0);
        check("release_ready", req_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_zero_buses"}, {wr_way, wr_addr, rd_addr, resp_status}, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    logic [KW-1:0] rkey;
    logic [VW-1:0] rval;
    int            seen_wr, seen_rsp;

    initial begin
        req_valid = 1'b0; req_opt = 1'b0; req_addr = '0; req_key = '0; req_value = '0;
        resp_ready = 1'b0;
        for (int w = 0; w < NM; w++) for (int b = 0; b < NW; b++) cur[w][b] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Insert into an all-zero table lands in the highest way, unencoded.
        run_txn(1'b0, 12'h021, 32'h1234, 31'h55, 0);
        check("ins_way", cap_way, 4'b1000);
        check("ins_data", cap_data, {1'b1, 31'h55, 32'h1234});

        // Update an existing key with the response held off for 5 cycles.
        ent[0] = {1'b1, 31'h3, 32'h1};
        ent[1] = {1'b1, 31'h11, 32'hABCD};
        ent[2] = {1'b1, 31'h4, 32'h2};
        ent[3] = {1'b0, 31'h5, 32'hABCD};
        fill_table();
        run_txn(1'b0, 12'h3A5, 32'hABCD, 31'h22, 5);
        check("upd_status", cap_status, E_UPD);
        check("upd_way", cap_way, 4'b0010);

        // Delete a present key.
        ent[0] = {1'b1, 31'h9, 32'h1};
        ent[1] = {1'b1, 31'h8, 32'h2};
        ent[2] = {1'b1, 31'h77, 32'h7};
        ent[3] = {1'b1, 31'h6, 32'h3};
        fill_table();
        run_txn(1'b1, 12'hFFF, 32'h7, 31'h1234, 1);
        check("del_status", cap_status, E_DEL);
        check("del_way", cap_way, 4'b0100);

        // Full table, missing key: write and delete both fail.
        for (int w = 0; w < NM; w++) ent[w] = {1'b1, 31'($urandom), 32'(w + 1)};
        fill_table();
        run_txn(1'b0, 12'h000, 32'h9, 31'h1, 0);
        check("full_status", cap_status, E_FAIL);
        run_txn(1'b1, 12'h000, 32'h9, 31'h1, 2);
        check("miss_del_status", cap_status, E_FAIL);

        // Reset while waiting on read data aborts without writing.
        for (int w = 0; w < NM; w++) ent[w] = '0;
        fill_table();
        @(negedge clk);
        cur_addr = 12'h055;
        req_valid = 1'b1; req_opt = 1'b0; req_addr = 12'h055; req_key = 32'h42; req_value = 31'h1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        seen_wr = 0; seen_rsp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_en) seen_wr++;
            if (resp_valid) seen_rsp++;
        end
        check("abort_no_write", 64'(seen_wr), 0);
        check("abort_no_resp", 64'(seen_rsp), 0);

        // Random tables with a small key pool so hits, duplicates and full sets occur.
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < NM; w++)
                ent[w] = {1'($urandom_range(0, 3) != 0), 31'($urandom), 32'($urandom_range(1, 4))};
            fill_table();
            rkey = 32'($urandom_range(1, 5));
            rval = 31'($urandom);
            run_txn(1'($urandom), AW'($urandom), rkey, rval, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
